// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I-subset core: sequences each instruction,
// drives the datapath selects and write enables, and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                Zero,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                RegWrite,
    output logic [1:0]          ImmSrc,
    output logic [2:0]          ALU_control,
    output logic                Illegal,
    output logic [RETIRE_W-1:0] InstrRetired
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecuteR, StExecuteI, StAluWb, StBranch, StJal
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic                 w_pc_update;
    logic                 w_branch;
    logic                 w_ir_write;
    logic                 w_mem_write;
    logic                 w_reg_write;
    logic [1:0]           w_alu_op;
    logic                 w_op_illegal;
    logic                 w_retire;
    logic [RETIRE_W-1:0]  r_retired;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_op_illegal = 1'b0;
        unique case (op)
            OpLoad, OpStore, OpRType, OpIType, OpBranch, OpJal: w_op_illegal = 1'b0;
            default:                                            w_op_illegal = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_next = StFetch;
        case (r_state)
            StFetch:  w_state_next = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: w_state_next = StMemAdr;
                    OpRType:         w_state_next = StExecuteR;
                    OpIType:         w_state_next = StExecuteI;
                    OpBranch:        w_state_next = StBranch;
                    OpJal:           w_state_next = StJal;
                    default:         w_state_next = StFetch;
                endcase
            end
            StMemAdr:   w_state_next = (op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  w_state_next = StMemWb;
            StExecuteR: w_state_next = StAluWb;
            StExecuteI: w_state_next = StAluWb;
            StJal:      w_state_next = StAluWb;
            default:    w_state_next = StFetch;
        endcase
    end

    // Moore outputs
    always_comb begin
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        w_alu_op    = 2'b00;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        case (r_state)
            StFetch: begin
                w_ir_write  = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            StMemWrite: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            StExecuteR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
            end
            StExecuteI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
            end
            StAluWb: w_reg_write = 1'b1;
            StBranch: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
            end
            StJal: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OpStore:  ImmSrc = 2'b01;
            OpBranch: ImmSrc = 2'b10;
            OpJal:    ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // funct7b5 only selects SUB for register-register ops (op[5]=1), never for addi
    always_comb begin
        ALU_control = AluAdd;
        case (w_alu_op)
            2'b01: ALU_control = AluSub;
            2'b10: begin
                case (funct3)
                    3'b000:  ALU_control = (op[5] & funct7b5) ? AluSub : AluAdd;
                    3'b010:  ALU_control = AluSlt;
                    3'b110:  ALU_control = AluOr;
                    3'b111:  ALU_control = AluAnd;
                    default: ALU_control = AluAdd;
                endcase
            end
            default: ALU_control = AluAdd;
        endcase
    end

    // Write enables are held low for as long as reset is asserted
    assign PCWrite  = rst_n & (w_pc_update | (w_branch & (Zero ^ funct3[0])));
    assign IRWrite  = rst_n & w_ir_write;
    assign MemWrite = rst_n & w_mem_write;
    assign RegWrite = rst_n & w_reg_write;
    assign Illegal  = (r_state == StDecode) & w_op_illegal;

    assign w_retire = (r_state == StMemWb) | (r_state == StMemWrite) |
                      (r_state == StAluWb) | (r_state == StBranch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    assign InstrRetired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the FSM,
// checking selects, enables, ALU_control and the (4-bit) retire counter.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [2:0] ALU_control;
    logic       Illegal;
    logic [3:0] InstrRetired;

    int n_pass;
    int n_total;

    multicycle_ctrl #(.RETIRE_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .RegWrite     (RegWrite),
        .ImmSrc       (ImmSrc),
        .ALU_control  (ALU_control),
        .Illegal      (Illegal),
        .InstrRetired (InstrRetired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: R-type through EXECUTER/ALUWB back to FETCH
    task automatic run_rtype(input string tag, input logic [2:0] f3, input logic f7,
                             input logic [2:0] exp_ctl);
        op       = 7'b0110011;
        funct3   = f3;
        funct7b5 = f7;
        step();
        step();
        chk(tag, 32'(ALU_control), exp_ctl);
        step();
        chk({tag, "_wb"}, 32'(RegWrite), 1);
        step();
    endtask

    // From FETCH: branch, returning to FETCH after 3 cycles
    task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                              input logic exp_pcw, input logic [3:0] exp_ret);
        op     = 7'b1100011;
        funct3 = f3;
        Zero   = z;
        step();
        chk({tag, "_imm"}, 32'(ImmSrc), 'h2);
        step();
        chk({tag, "_pcw"}, 32'(PCWrite), 32'(exp_pcw));
        chk({tag, "_alu"}, 32'(ALU_control), 'h1);
        step();
        chk({tag, "_fetch"}, 32'(IRWrite), 1);
        chk({tag, "_ret"}, 32'(InstrRetired), 32'(exp_ret));
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        op       = 7'b0000000;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        Zero     = 1'b0;

        // Reset held over three edges
        step();
        step();
        step();
        chk("rst_pcw", 32'(PCWrite), 0);
        chk("rst_irw", 32'(IRWrite), 0);
        chk("rst_memw", 32'(MemWrite), 0);
        chk("rst_regw", 32'(RegWrite), 0);
        chk("rst_ret", 32'(InstrRetired), 0);
        #4 rst_n = 1'b1;
        #1;
        chk("fetch_irw", 32'(IRWrite), 1);
        chk("fetch_pcw", 32'(PCWrite), 1);
        chk("fetch_srcb", 32'(ALUSrcB), 'h2);
        chk("fetch_alu", 32'(ALU_control), 0);
        chk("fetch_res", 32'(ResultSrc), 'h2);

        // lw: FETCH DECODE MEMADR MEMREAD MEMWB
        op = 7'b0000011;
        chk("lw_f_regw", 32'(RegWrite), 0);
        step();
        chk("lw_dec_srca", 32'(ALUSrcA), 'h1);
        chk("lw_dec_srcb", 32'(ALUSrcB), 'h1);
        chk("lw_dec_imm", 32'(ImmSrc), 0);
        chk("lw_dec_regw", 32'(RegWrite), 0);
        step();
        chk("lw_adr_srca", 32'(ALUSrcA), 'h2);
        chk("lw_adr_regw", 32'(RegWrite), 0);
        step();
        chk("lw_rd_adr", 32'(AdrSrc), 1);
        chk("lw_rd_regw", 32'(RegWrite), 0);
        step();
        chk("lw_wb_regw", 32'(RegWrite), 1);
        chk("lw_wb_res", 32'(ResultSrc), 'h1);
        chk("lw_wb_ret", 32'(InstrRetired), 0);
        step();
        chk("lw_fetch", 32'(IRWrite), 1);
        chk("lw_ret", 32'(InstrRetired), 1);

        run_rtype("sub", 3'b000, 1'b1, 3'b001);
        run_rtype("add", 3'b000, 1'b0, 3'b000);
        run_rtype("slt", 3'b010, 1'b0, 3'b101);
        run_rtype("or",  3'b110, 1'b0, 3'b011);
        run_rtype("and", 3'b111, 1'b0, 3'b010);
        chk("rtype_ret", 32'(InstrRetired), 6);

        run_branch("beq_taken", 3'b000, 1'b1, 1'b1, 4'd7);
        run_branch("beq_not",   3'b000, 1'b0, 1'b0, 4'd8);
        run_branch("bne_taken", 3'b001, 1'b0, 1'b1, 4'd9);
        Zero = 1'b0;

        // Illegal opcode: one DECODE pulse then FETCH, not counted
        op = 7'b1110011;
        chk("ill_fetch", 32'(Illegal), 0);
        step();
        chk("ill_pulse", 32'(Illegal), 1);
        step();
        chk("ill_after", 32'(Illegal), 0);
        chk("ill_fetch2", 32'(IRWrite), 1);
        chk("ill_ret", 32'(InstrRetired), 9);

        // sw: FETCH DECODE MEMADR MEMWRITE
        op = 7'b0100011;
        chk("sw_f_memw", 32'(MemWrite), 0);
        step();
        chk("sw_imm", 32'(ImmSrc), 'h1);
        chk("sw_dec_memw", 32'(MemWrite), 0);
        step();
        chk("sw_adr_memw", 32'(MemWrite), 0);
        step();
        chk("sw_wr_memw", 32'(MemWrite), 1);
        chk("sw_wr_adr", 32'(AdrSrc), 1);
        step();
        chk("sw_fetch_memw", 32'(MemWrite), 0);
        chk("sw_ret", 32'(InstrRetired), 10);

        // jal: FETCH DECODE JAL ALUWB
        op = 7'b1101111;
        step();
        chk("jal_imm", 32'(ImmSrc), 'h3);
        step();
        chk("jal_pcw", 32'(PCWrite), 1);
        chk("jal_srca", 32'(ALUSrcA), 'h1);
        step();
        chk("jal_wb", 32'(RegWrite), 1);
        step();
        chk("jal_ret", 32'(InstrRetired), 11);

        // Half-cycle reset pulse in the middle of a lw
        op = 7'b0000011;
        step();
        step();
        step();
        chk("mid_rd_adr", 32'(AdrSrc), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_adr", 32'(AdrSrc), 0);
        chk("mid_rst_irw", 32'(IRWrite), 0);
        chk("mid_rst_ret", 32'(InstrRetired), 0);
        op       = 7'b0010011;
        funct3   = 3'b000;
        funct7b5 = 1'b1;
        #4 rst_n = 1'b1;
        #1;
        chk("mid_fetch_irw", 32'(IRWrite), 1);
        chk("mid_fetch_srcb", 32'(ALUSrcB), 'h2);

        // 16 addi with Instr[30]=1: ADD, and the 4-bit counter wraps
        for (int i = 0; i < 16; i++) begin
            step();
            step();
            if (i == 0) begin
                chk("addi_alu", 32'(ALU_control), 0);
                chk("addi_srcb", 32'(ALUSrcB), 'h1);
            end
            step();
            step();
            if (i == 14) chk("addi_ret15", 32'(InstrRetired), 'hf);
        end
        chk("addi_wrap", 32'(InstrRetired), 0);
        chk("addi_fetch", 32'(IRWrite), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control unit for the multicycle RV32I-subset core. It sits directly upstream of the ALU and drives its 3-bit ALU_control.
- A main FSM sequences each instruction: fetch, decode, execute, memory and writeback.
- It generates the datapath mux selects and write enables, plus a retired-instruction counter.
- ALU_control encodings match the ALU: ADD=000, SUB=001, AND=010, OR=011, SLT=101.

Parameters:
RETIRE_W, 32, width of the InstrRetired counter.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
op  input  7  Instr[6:0] from the instruction register.
funct3  input  3  Instr[14:12].
funct7b5  input  1  Instr[30].
Zero  input  1  ALU Zero flag.
PCWrite  output  1  PC register enable.
AdrSrc  output  1  memory address select: 0=PC, 1=Result.
MemWrite  output  1  data memory write enable.
IRWrite  output  1  instruction register / OldPC enable.
ResultSrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALU_result.
ALUSrcA  output  2  SrcA mux: 00=PC, 01=OldPC, 10=A (rs1).
ALUSrcB  output  2  SrcB mux: 00=B (rs2), 01=ImmExt, 10=constant 4.
RegWrite  output  1  register file write enable.
ImmSrc  output  2  immediate type: 00=I, 01=S, 10=B, 11=J.
ALU_control  output  3  ALU operation select.
Illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode.
InstrRetired  output  RETIRE_W  count of completed instructions.

Behaviour:
- State register: async clear to FETCH when rst_n=0; otherwise it updates on the rising edge of clk. InstrRetired clears to 0 the same way.
- Write gating: while rst_n=0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. All other outputs are don't-care during reset but must be X-free.
- Outputs are combinational (Moore) from state, except:
  - PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])). This covers beq (funct3=000) and bne (funct3=001).
  - ImmSrc is decoded from op alone: lw/addi-class 00, sw 01, branch 10, jal 11, others 00.
- Per-state outputs; anything unlisted is 0 / 00:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE, by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BRANCH; 1101111 -> JAL; any other op -> FETCH with Illegal=1.
  - MEMADR -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH.
  - EXECUTER/EXECUTEI->ALUWB->FETCH. JAL->ALUWB. BRANCH->FETCH.
  - Unreachable encodings -> FETCH.
- Cycle counts: lw 5, sw 4, R/I-type 4, branch 3, jal 4, illegal 2.
- ALU decoder (internal 2-bit ALUOp):
  - 00 -> ADD; 01 -> SUB; 11 -> ADD.
  - 10, by funct3: 000 -> SUB if (op[5] & funct7b5) else ADD (so addi with Instr[30]=1 stays ADD); 010 -> SLT; 110 -> OR; 111 -> AND; any other funct3 -> ADD.
- InstrRetired:
  - Increments by 1 on the clock edge leaving MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Illegal instructions are never counted.
  - Wraps from all-ones to 0 with no flag.
- Reset mid-instruction: the FSM returns to FETCH immediately (asynchronously); a partial instruction is not counted.

Test Plan:
- Reset: hold rst_n=0 across 3 clocks in FETCH -> PCWrite=IRWrite=MemWrite=RegWrite=0, InstrRetired=0. Release -> next cycle shows FETCH outputs: IRWrite=1, PCWrite=1, ALUSrcB=10, ALU_control=000.
- lw (op=0000011): 5 cycles FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - RegWrite=1 only in MEMWB, with ResultSrc=01.
  - InstrRetired 0->1 after MEMWB.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALU_control=001 in EXECUTER. Same with funct7b5=0 -> 000. slt (funct3=010) -> 101. or (funct3=110) -> 011. and (funct3=111) -> 010.
- beq, funct3=000:
  - Zero=1 in BRANCH -> PCWrite=1, ALU_control=001.
  - Zero=0 -> PCWrite=0.
  - bne (funct3=001) with Zero=0 -> PCWrite=1.
  - Each case is 3 cycles and retires 1.
- Illegal op=1110011 -> Illegal=1 for exactly the DECODE cycle, next state FETCH, InstrRetired unchanged. Then sw (op=0100011) -> MemWrite=1 only in MEMWRITE, ImmSrc=01, retired +1.
- Pulse rst_n=0 for half a cycle during MEMREAD -> state is FETCH before the next edge and InstrRetired=0. With RETIRE_W=4, 16 addi instructions -> counter wraps to 0.
